// File: rtl/lifo_stack_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_stack_ctrl_if
//  Description : Request/status and RAM-control bundle for the LIFO stack
//                controller. The shared tri-state data bus is not part of
//                this bundle; it is a plain inout on the controller so the
//                resolved net lives in one place.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lifo_stack_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   // requester side
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              valid;
   logic              busy;
   logic              full;
   logic              empty;
   logic              err;
   // RAM control side
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wen;
   logic              ram_rws;
   logic              ram_cs;

   // environment that issues requests and observes the RAM controls
   modport master (
      output push, pop, din,
      input  dout, valid, busy, full, empty, err,
      input  ram_addr, ram_wen, ram_rws, ram_cs
   );

   // the stack controller itself
   modport slave (
      input  push, pop, din,
      output dout, valid, busy, full, empty, err,
      output ram_addr, ram_wen, ram_rws, ram_cs
   );
endinterface
`default_nettype wire

// File: rtl/lifo_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_stack_ctrl
//  Description : LIFO stack controller in front of a single-port tri-state
//                RAM. Tracks the stack pointer and FULL/EMPTY, sequences a
//                three-cycle write (setup, strobe, hold) and a two-cycle read
//                (setup, capture), and owns the shared RAM data bus.
//                Optional macro LIFO_ERR_FLAG_EN enables the sticky ERR flag
//                for push-when-full / pop-when-empty; otherwise ERR is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  wire                    clk,
   input  wire                    rst_n,
   lifo_stack_ctrl_if.slave       bus,
   inout  wire [DATA_W-1:0]       ram_io
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_W_SET = 3'd1,
      S_W_STB = 3'd2,
      S_W_HLD = 3'd3,
      S_R_SET = 3'd4,
      S_R_CAP = 3'd5
   } state_t;

   localparam logic [ADDR_W:0]   c_sp_full = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   c_sp_one  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

   state_t              r_state;
   state_t              w_next_state;

   logic [ADDR_W:0]     r_sp;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_dout;
   logic                r_valid;
   logic                r_busy;

   logic [ADDR_W-1:0]   r_ram_addr;
   logic                r_ram_wen;
   logic                r_ram_rws;
   logic                r_ram_cs;

   logic [ADDR_W-1:0]   w_ram_addr_nxt;
   logic                w_ram_wen_nxt;
   logic                w_ram_rws_nxt;
   logic                w_ram_cs_nxt;

   logic                w_full;
   logic                w_empty;
   logic                w_push_ok;
   logic                w_pop_ok;
   logic [ADDR_W-1:0]   w_top_addr;

   // Flags come straight from the pointer so they move on the same edge as SP.
   assign w_full  = (r_sp == c_sp_full);
   assign w_empty = (r_sp == '0);

   // Top of stack lives at SP-1; the low bits alone give the right address
   // even when SP==DEPTH (0 - 1 wraps to DEPTH-1).
   assign w_top_addr = r_sp[ADDR_W-1:0] - c_addr_one;

   // Request acceptance in IDLE; push wins, a coincident pop is dropped.
   assign w_push_ok = bus.push && !w_full;
   assign w_pop_ok  = !w_push_ok && bus.pop && !w_empty;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and the RAM control values each target state asks for.
   always_comb begin
      w_next_state   = r_state;
      w_ram_addr_nxt = '0;
      w_ram_wen_nxt  = 1'b0;
      w_ram_rws_nxt  = 1'b0;
      w_ram_cs_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_push_ok) begin
               w_next_state = S_W_SET;
            end else if (w_pop_ok) begin
               w_next_state = S_R_SET;
            end
         end
         S_W_SET: w_next_state = S_W_STB;
         S_W_STB: w_next_state = S_W_HLD;
         S_W_HLD: w_next_state = S_IDLE;
         S_R_SET: w_next_state = S_R_CAP;
         S_R_CAP: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase

      // Controls are decoded from the state being entered so the registered
      // outputs line up exactly with the state they belong to.
      case (w_next_state)
         S_W_SET, S_W_HLD: begin
            w_ram_addr_nxt = r_sp[ADDR_W-1:0];
            w_ram_rws_nxt  = 1'b1;
         end
         S_W_STB: begin
            w_ram_addr_nxt = r_sp[ADDR_W-1:0];
            w_ram_rws_nxt  = 1'b1;
            w_ram_cs_nxt   = 1'b1;
            w_ram_wen_nxt  = 1'b1;
         end
         S_R_SET, S_R_CAP: begin
            w_ram_addr_nxt = w_top_addr;
            w_ram_cs_nxt   = 1'b1;
            w_ram_wen_nxt  = 1'b1;
         end
         default: begin
            w_ram_addr_nxt = '0;
         end
      endcase
   end

   // Registered RAM controls and BUSY, free of decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_addr <= '0;
         r_ram_wen  <= 1'b0;
         r_ram_rws  <= 1'b0;
         r_ram_cs   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_ram_addr <= w_ram_addr_nxt;
         r_ram_wen  <= w_ram_wen_nxt;
         r_ram_rws  <= w_ram_rws_nxt;
         r_ram_cs   <= w_ram_cs_nxt;
         r_busy     <= (w_next_state != S_IDLE);
      end
   end

   // Capture push data on acceptance; it is held on the bus for the whole write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdata <= '0;
      end else if (r_state == S_IDLE && w_push_ok) begin
         r_wdata <= bus.din;
      end
   end

   // Stack pointer: bump on leaving W_HLD, drop on leaving R_CAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp <= '0;
      end else if (r_state == S_W_HLD) begin
         r_sp <= r_sp + c_sp_one;
      end else if (r_state == S_R_CAP) begin
         r_sp <= r_sp - c_sp_one;
      end
   end

   // Pop result: sample the RAM bus on leaving R_CAP and pulse VALID once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= (r_state == S_R_CAP);
         if (r_state == S_R_CAP) begin
            r_dout <= ram_io;
         end
      end
   end

   // The bus is driven exactly when RWS says write, so the controller can
   // never fight the RAM during a read.
   assign ram_io = r_ram_rws ? r_wdata : {DATA_W{1'bz}};

`ifdef LIFO_ERR_FLAG_EN
   logic r_err;

   // Sticky: any refused request seen in IDLE latches ERR until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (r_state == S_IDLE &&
                   ((bus.push && w_full) || (bus.pop && w_empty))) begin
         r_err <= 1'b1;
      end
   end

   assign bus.err = r_err;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.dout     = r_dout;
   assign bus.valid    = r_valid;
   assign bus.busy     = r_busy;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.ram_addr = r_ram_addr;
   assign bus.ram_wen  = r_ram_wen;
   assign bus.ram_rws  = r_ram_rws;
   assign bus.ram_cs   = r_ram_cs;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo_stack_ctrl
//  Description : Directed bench for lifo_stack_ctrl with a behavioural
//                32x8 tri-state RAM on the shared bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_stack_ctrl;

`ifdef LIFO_ERR_FLAG_EN
   localparam bit c_err_en = 1'b1;
`else
   localparam bit c_err_en = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       probe_en;
   wire  [7:0] ram_io;
   logic [7:0] mem [0:31];
   int         checks;
   int         errors;
   logic       exp_err;

   lifo_stack_ctrl_if #(.DATA_W(8), .ADDR_W(5)) bus ();

   lifo_stack_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .ram_io (ram_io)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM drives the bus on a read access; probe drives a marker to show the bus is free
   assign ram_io = (bus.ram_cs && !bus.ram_rws) ? mem[bus.ram_addr] :
                   (probe_en ? 8'h3C : 8'hzz);

   // RAM write on strobe
   always @(posedge clk) begin
      if (bus.ram_cs && bus.ram_wen && bus.ram_rws)
         mem[bus.ram_addr] <= ram_io;
   end

   task automatic do_push(input logic [7:0] d);
      @(negedge clk); bus.push = 1'b1; bus.din = d;
      @(negedge clk); bus.push = 1'b0; bus.din = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   // returns just after the capture edge (VALID visible)
   task automatic do_pop();
      @(negedge clk); bus.pop = 1'b1;
      @(negedge clk); bus.pop = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.valid !== 1'b0 || bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout valid=%b dout=%h exp 0/00", bus.valid, bus.dout); end
      checks++; if (bus.ram_cs !== 1'b0 || bus.ram_wen !== 1'b0 || bus.ram_rws !== 1'b0 || bus.ram_addr !== 5'd0) begin
         errors++; $display("FAIL reset_ramctl cs=%b wen=%b rws=%b addr=%0d exp all 0", bus.ram_cs, bus.ram_wen, bus.ram_rws, bus.ram_addr); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      probe_en = 1'b1; #1;
      checks++; if (ram_io !== 8'h3C) begin errors++; $display("FAIL reset_bus_released got=%h exp=3c", ram_io); end
      probe_en = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk); bus.push = 1'b1; bus.din = 8'hA5;
      @(negedge clk); bus.push = 1'b0; bus.din = 8'h00;
      checks++; if (bus.busy !== 1'b1 || bus.ram_rws !== 1'b1 || bus.ram_cs !== 1'b0 || bus.ram_wen !== 1'b0 || bus.ram_addr !== 5'd0) begin
         errors++; $display("FAIL wset_ctl busy=%b rws=%b cs=%b wen=%b addr=%0d exp 1/1/0/0/0", bus.busy, bus.ram_rws, bus.ram_cs, bus.ram_wen, bus.ram_addr); end
      checks++; if (ram_io !== 8'hA5) begin errors++; $display("FAIL wset_bus got=%h exp=a5", ram_io); end
      @(negedge clk);
      checks++; if (bus.ram_cs !== 1'b1 || bus.ram_wen !== 1'b1 || bus.ram_rws !== 1'b1 || ram_io !== 8'hA5) begin
         errors++; $display("FAIL wstb_ctl cs=%b wen=%b rws=%b bus=%h exp 1/1/1/a5", bus.ram_cs, bus.ram_wen, bus.ram_rws, ram_io); end
      @(negedge clk);
      checks++; if (bus.ram_cs !== 1'b0 || bus.ram_wen !== 1'b0 || bus.ram_rws !== 1'b1 || ram_io !== 8'hA5 || bus.busy !== 1'b1 || bus.empty !== 1'b1) begin
         errors++; $display("FAIL whld_ctl cs=%b wen=%b rws=%b bus=%h busy=%b empty=%b exp 0/0/1/a5/1/1", bus.ram_cs, bus.ram_wen, bus.ram_rws, ram_io, bus.busy, bus.empty); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.empty !== 1'b0 || bus.ram_rws !== 1'b0) begin
         errors++; $display("FAIL push_done busy=%b empty=%b rws=%b exp 0/0/0", bus.busy, bus.empty, bus.ram_rws); end
      // pop
      @(negedge clk); bus.pop = 1'b1;
      @(negedge clk); bus.pop = 1'b0;
      checks++; if (bus.busy !== 1'b1 || bus.ram_cs !== 1'b1 || bus.ram_wen !== 1'b1 || bus.ram_rws !== 1'b0 || bus.ram_addr !== 5'd0 || ram_io !== 8'hA5) begin
         errors++; $display("FAIL rset_ctl busy=%b cs=%b wen=%b rws=%b addr=%0d bus=%h exp 1/1/1/0/0/a5", bus.busy, bus.ram_cs, bus.ram_wen, bus.ram_rws, bus.ram_addr, ram_io); end
      @(negedge clk);
      checks++; if (bus.valid !== 1'b0 || bus.empty !== 1'b0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL rcap_state valid=%b empty=%b busy=%b exp 0/0/1", bus.valid, bus.empty, bus.busy); end
      @(negedge clk);
      checks++; if (bus.valid !== 1'b1 || bus.dout !== 8'hA5 || bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL pop_done valid=%b dout=%h empty=%b busy=%b exp 1/a5/1/0", bus.valid, bus.dout, bus.empty, bus.busy); end
      @(negedge clk);
      checks++; if (bus.valid !== 1'b0 || bus.dout !== 8'hA5) begin
         errors++; $display("FAIL valid_pulse valid=%b dout=%h exp 0/a5", bus.valid, bus.dout); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 31; i++) do_push(8'(i));
      checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b0) begin
         errors++; $display("FAIL fill31_flags full=%b empty=%b exp 0/0", bus.full, bus.empty); end
      @(negedge clk); bus.push = 1'b1; bus.din = 8'h1F;
      @(negedge clk); bus.push = 1'b0; bus.din = 8'h00;
      checks++; if (bus.ram_addr !== 5'd31 || bus.ram_rws !== 1'b1) begin
         errors++; $display("FAIL push_addr31 addr=%0d rws=%b exp 31/1", bus.ram_addr, bus.ram_rws); end
      repeat (3) @(negedge clk);
      checks++; if (bus.full !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL fill32_full full=%b busy=%b exp 1/0", bus.full, bus.busy); end
      // extra push is refused
      @(negedge clk); bus.push = 1'b1; bus.din = 8'hEE;
      @(negedge clk); bus.push = 1'b0; bus.din = 8'h00;
      if (c_err_en) exp_err = 1'b1;
      checks++; if (bus.busy !== 1'b0 || bus.ram_cs !== 1'b0 || bus.ram_rws !== 1'b0 || bus.full !== 1'b1) begin
         errors++; $display("FAIL overflow_ignored busy=%b cs=%b rws=%b full=%b exp 0/0/0/1", bus.busy, bus.ram_cs, bus.ram_rws, bus.full); end
      checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL overflow_err got=%b exp=%b", bus.err, exp_err); end
      for (int i = 0; i < 32; i++) begin
         do_pop();
         checks++; if (bus.valid !== 1'b1 || bus.dout !== 8'(31 - i)) begin
            errors++; $display("FAIL drain_%0d valid=%b dout=%h exp 1/%h", i, bus.valid, bus.dout, 8'(31 - i)); end
      end
      checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         errors++; $display("FAIL drain_flags empty=%b full=%b exp 1/0", bus.empty, bus.full); end
   endtask

   task automatic test_underflow();
      do_push(8'h5C);
      do_pop();
      checks++; if (bus.dout !== 8'h5C) begin errors++; $display("FAIL uf_setup dout=%h exp=5c", bus.dout); end
      @(negedge clk); bus.pop = 1'b1;
      @(negedge clk); bus.pop = 1'b0;
      if (c_err_en) exp_err = 1'b1;
      checks++; if (bus.busy !== 1'b0 || bus.ram_cs !== 1'b0) begin
         errors++; $display("FAIL uf_no_access busy=%b cs=%b exp 0/0", bus.busy, bus.ram_cs); end
      repeat (3) @(negedge clk);
      checks++; if (bus.dout !== 8'h5C || bus.valid !== 1'b0 || bus.empty !== 1'b1) begin
         errors++; $display("FAIL uf_hold dout=%h valid=%b empty=%b exp 5c/0/1", bus.dout, bus.valid, bus.empty); end
      checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL uf_err got=%b exp=%b", bus.err, exp_err); end
      probe_en = 1'b1; #1;
      checks++; if (ram_io !== 8'h3C) begin errors++; $display("FAIL uf_bus_released got=%h exp=3c", ram_io); end
      probe_en = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_push(8'h11);
      do_push(8'h22);
      @(negedge clk); bus.push = 1'b1; bus.pop = 1'b1; bus.din = 8'h33;
      @(negedge clk); bus.push = 1'b0; bus.pop = 1'b0; bus.din = 8'h00;
      checks++; if (bus.ram_rws !== 1'b1 || bus.ram_addr !== 5'd2 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL simul_push_wins rws=%b addr=%0d busy=%b exp 1/2/1", bus.ram_rws, bus.ram_addr, bus.busy); end
      repeat (3) @(negedge clk);
      do_pop();
      checks++; if (bus.dout !== 8'h33) begin errors++; $display("FAIL simul_pop0 dout=%h exp=33", bus.dout); end
      do_pop();
      checks++; if (bus.dout !== 8'h22) begin errors++; $display("FAIL simul_pop1 dout=%h exp=22", bus.dout); end
      do_pop();
      checks++; if (bus.dout !== 8'h11 || bus.empty !== 1'b1) begin
         errors++; $display("FAIL simul_pop2 dout=%h empty=%b exp 11/1", bus.dout, bus.empty); end
   endtask

   task automatic test_reset_mid_write();
      for (int i = 0; i < 5; i++) do_push(8'h40 + 8'(i));
      @(negedge clk); bus.push = 1'b1; bus.din = 8'h77;
      @(negedge clk); bus.push = 1'b0; bus.din = 8'h00;
      @(negedge clk);
      checks++; if (bus.ram_cs !== 1'b1 || bus.ram_addr !== 5'd5) begin
         errors++; $display("FAIL mid_wstb cs=%b addr=%0d exp 1/5", bus.ram_cs, bus.ram_addr); end
      #1 rst_n = 1'b0;
      exp_err = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.ram_cs !== 1'b0 || bus.ram_wen !== 1'b0 || bus.ram_rws !== 1'b0 || bus.ram_addr !== 5'd0 ||
                    bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.dout !== 8'h00 || bus.err !== 1'b0) begin
         errors++; $display("FAIL mid_reset busy=%b cs=%b wen=%b rws=%b addr=%0d empty=%b full=%b dout=%h err=%b",
                            bus.busy, bus.ram_cs, bus.ram_wen, bus.ram_rws, bus.ram_addr, bus.empty, bus.full, bus.dout, bus.err); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); bus.pop = 1'b1;
      @(negedge clk); bus.pop = 1'b0;
      if (c_err_en) exp_err = 1'b1;
      checks++; if (bus.busy !== 1'b0 || bus.ram_cs !== 1'b0 || bus.empty !== 1'b1) begin
         errors++; $display("FAIL post_reset_pop busy=%b cs=%b empty=%b exp 0/0/1", bus.busy, bus.ram_cs, bus.empty); end
      repeat (2) @(negedge clk);
      checks++; if (bus.valid !== 1'b0 || bus.dout !== 8'h00 || bus.err !== exp_err) begin
         errors++; $display("FAIL post_reset_out valid=%b dout=%h err=%b exp 0/00/%b", bus.valid, bus.dout, bus.err, exp_err); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      exp_err  = 1'b0;
      probe_en = 1'b0;
      rst_n    = 1'b0;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.din  = 8'h00;
      for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
      test_reset();
      test_single();
      test_fill_drain();
      test_underflow();
      test_simultaneous();
      test_reset_mid_write();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lifo_stack_ctrl.md
Name: lifo_stack_ctrl

Overview:
- Sequential controller directly upstream of the 32-word x 8-bit tri-state RAM in the LIFO path.
- Accepts PUSH/POP requests and maintains the stack pointer and FULL/EMPTY flags.
- Generates the RAM address, decoder enable, read/write select and chip select, and owns the shared 8-bit IO bus: drives it for writes and samples it for reads.

Parameters:
- DATA_W, 8, data width; must match the RAM word width.
- ADDR_W, 5, RAM address width.
- DEPTH, 32, number of stack entries; equals 2**ADDR_W.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- PUSH  input  1  push request; sampled only when BUSY=0.
- POP  input  1  pop request; sampled only when BUSY=0.
- DIN  input  DATA_W  push data; captured in the cycle PUSH is accepted.
- DOUT  output  DATA_W  popped data; registered.
- VALID  output  1  one-cycle pulse when DOUT is updated by a pop.
- BUSY  output  1  high while an operation is in progress.
- FULL  output  1  SP==DEPTH.
- EMPTY  output  1  SP==0.
- ERR  output  1  sticky error flag; see Optional Feature.
- RAM_IO  inout  DATA_W  shared RAM data bus.
- RAM_ADDR  output  ADDR_W  RAM word select (decoder input).
- RAM_WEN  output  1  decoder enable.
- RAM_RWS  output  1  1=write, 0=read.
- RAM_CS  output  1  chip select.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST_N is asynchronous, active-low.
- Reset values: SP=0, DOUT=0, VALID=0, BUSY=0, FULL=0, EMPTY=1, ERR=0, RAM_ADDR=0, RAM_WEN=0, RAM_RWS=0, RAM_CS=0, RAM_IO released (high-Z). State goes to IDLE.
- Reset mid-operation aborts immediately: stack becomes empty and RAM contents are don't-care.
- SP is ADDR_W+1 bits wide, range 0..DEPTH. Entry N occupies address N. Top of stack is at SP-1.
- States: IDLE, W_SET, W_STB, W_HLD, R_SET, R_CAP. All RAM control outputs are registered, taking their state-decoded values, so they are glitch-free.
- IDLE:
  - BUSY=0 and all RAM controls are deasserted.
  - PUSH with FULL=0: latch DIN into a data register, go to W_SET.
  - Otherwise, POP with EMPTY=0: go to R_SET.
  - PUSH has priority when PUSH and POP arrive together. The POP is dropped, not queued.
  - PUSH with FULL=1 or POP with EMPTY=1: ignored, state stays IDLE, SP unchanged.
- W_SET:
  - RAM_ADDR=SP[ADDR_W-1:0], RAM_RWS=1, RAM_CS=0, RAM_WEN=0.
  - RAM_IO driven with the latched data (setup cycle).
  - Go to W_STB.
- W_STB: as W_SET but RAM_CS=1 and RAM_WEN=1 (write strobe). Go to W_HLD.
- W_HLD:
  - RAM_CS=0 and RAM_WEN=0. Address, RWS and RAM_IO are held (hold cycle).
  - Go to IDLE. SP increments on this exit edge.
- R_SET:
  - RAM_ADDR=SP-1, RAM_RWS=0, RAM_CS=1, RAM_WEN=1.
  - RAM_IO released; the RAM drives it.
  - Go to R_CAP.
- R_CAP:
  - Controls held as in R_SET.
  - On the exit edge: DOUT<=RAM_IO, VALID<=1 for the next cycle, SP decrements. Go to IDLE.
- Bus rule: the controller drives RAM_IO only in W_SET, W_STB and W_HLD. It never drives while RAM_RWS=0.
- Latency, counting the acceptance edge as edge 0:
  - Push: BUSY high for 3 cycles; SP/FULL/EMPTY update after edge 3.
  - Pop: BUSY high for 2 cycles; DOUT/VALID/SP/EMPTY update after edge 2.
  - Back-to-back operations are accepted the cycle BUSY returns low.
- Wrap: SP never wraps. A push at SP=31 writes address 31, then SP=32 and FULL=1.
- DOUT holds its last popped value until the next pop.

Optional Feature:
- Macro: LIFO_ERR_FLAG_EN.
- Defined: a PUSH while FULL=1 or a POP while EMPTY=1, sampled in IDLE, sets ERR. ERR is sticky and is cleared only by RST_N.
- Not defined: ERR is tied to 0 and no error logic is synthesised.
- Push/pop behaviour is identical in both builds.

Test Plan:
- Reset check: RST_N low, then release -> EMPTY=1, FULL=0, BUSY=0, SP=0, RAM_CS=0, RAM_IO high-Z.
- Single push/pop: push 0xA5 -> RAM_ADDR=0, RAM_RWS=1, one-cycle RAM_CS/RAM_WEN strobe, EMPTY=0 after 3 cycles. Then pop -> DOUT=0xA5, VALID one-cycle pulse, EMPTY=1.
- Fill and drain: push 0x00..0x1F -> FULL=1 after the 32nd push. An extra push is ignored (ERR=1 if LIFO_ERR_FLAG_EN). Pop 32 times -> DOUT sequence 0x1F..0x00, EMPTY=1.
- Underflow: pop while empty -> no RAM access, SP=0, DOUT unchanged (ERR=1 if LIFO_ERR_FLAG_EN).
- Simultaneous PUSH+POP with 2 entries stored -> push executes, pop dropped, 3 entries afterwards.
- Reset during W_STB after 5 pushes -> all outputs return to reset values and the next pop is ignored (stack empty).
